// File: rtl/fc_layer_sequencer_pkg.sv
// Shared types and fixed-point helpers for the fully-connected layer sequencer.
package fc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_MAC   = 3'd2,
    ST_DRAIN = 3'd3,
    ST_WRITE = 3'd4,
    ST_DONE  = 3'd5
  } fc_state_e;

  // Counter/address width that never collapses to zero bits for size-1 layers.
  function automatic int clog2_min1(input int n);
    if (n > 32'sd1) return $clog2(n);
    else            return 32'sd1;
  endfunction

  // Largest value representable in a signed value of 'size' bits.
  function automatic logic signed [63:0] sat_max(input int size);
    return (64'sd1 <<< (size - 32'sd1)) - 64'sd1;
  endfunction

  // Smallest value representable in a signed value of 'size' bits.
  function automatic logic signed [63:0] sat_min(input int size);
    return 64'sd0 - (64'sd1 <<< (size - 32'sd1));
  endfunction

  // Drop the fractional product bits, then clamp into the value range.
  function automatic logic signed [63:0] sat_shift(input logic signed [63:0] acc,
                                                   input int frac, input int size);
    logic signed [63:0] sh;
    sh = acc >>> frac;
    if (sh > sat_max(size))      return sat_max(size);
    else if (sh < sat_min(size)) return sat_min(size);
    else                         return sh;
  endfunction

endpackage

// File: rtl/fc_layer_sequencer_if.sv
// Bus between the sequencer (master) and its neuron layers / weight memory (slave).
interface fc_layer_sequencer_if
  import fc_pkg::*;
#(
  parameter int SIZE   = 16,
  parameter int IN_SZ  = 4,
  parameter int OUT_SZ = 2
);
  localparam int AW = clog2_min1(IN_SZ * OUT_SZ);

  logic                             start;
  logic                             busy;
  logic                             done;
  logic [0:IN_SZ-1][SIZE-1:0]       in_values;
  logic                             w_rd_en;
  logic [AW-1:0]                    w_rd_addr;
  logic [SIZE-1:0]                  w_rd_data;
  logic                             layer_clear;
  logic                             load_en;
  logic [SIZE-1:0]                  load_address;
  logic [SIZE-1:0]                  load_value;

  modport master (
    input  start, in_values, w_rd_data,
    output busy, done, w_rd_en, w_rd_addr, layer_clear, load_en, load_address, load_value
  );

  modport slave (
    output start, in_values, w_rd_data,
    input  busy, done, w_rd_en, w_rd_addr, layer_clear, load_en, load_address, load_value
  );
endinterface

// File: rtl/fc_layer_sequencer_mac.sv
// Signed multiply-accumulate with clear; exposes the activated result of the
// next accumulator value so the sequencer can register it on the WRITE entry.
import fc_pkg::*;

module fc_mac_unit #(
  parameter int SIZE     = 16,
  parameter int FRAC     = 8,
  parameter int ACC_W    = 40,
  parameter int ACT_RELU = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   clear_i,
  input  logic                   acc_en_i,
  input  logic signed [SIZE-1:0] a_i,
  input  logic signed [SIZE-1:0] b_i,
  output logic signed [SIZE-1:0] result_o
);
  logic signed [ACC_W-1:0]  acc_q;
  logic signed [ACC_W-1:0]  acc_d;
  logic signed [2*SIZE-1:0] prod_s;
  logic signed [SIZE-1:0]   sat_s;

  // Full-precision product and next accumulator value (clear wins over accumulate).
  always_comb begin
    prod_s = (2*SIZE)'(a_i) * (2*SIZE)'(b_i);
    if (clear_i)       acc_d = {ACC_W{1'b0}};
    else if (acc_en_i) acc_d = acc_q + ACC_W'(prod_s);
    else               acc_d = acc_q;
  end

  // Rescale, saturate and optionally rectify the next accumulator value.
  always_comb begin
    sat_s = SIZE'(sat_shift(64'(acc_d), FRAC, SIZE));
    if ((ACT_RELU != 32'sd0) && sat_s[SIZE-1]) result_o = {SIZE{1'b0}};
    else                                       result_o = sat_s;
  end

  // Accumulator register.
  always_ff @(posedge clk) begin
    if (reset) acc_q <= {ACC_W{1'b0}};
    else       acc_q <= acc_d;
  end
endmodule

// File: rtl/fc_layer_sequencer.sv
// Fully-connected layer sequencer: streams weights, accumulates one output
// neuron at a time and writes each activated result into the output layer.
// All outputs are registered from next-state decode so they line up with the state.
import fc_pkg::*;

module fc_layer_sequencer #(
  parameter int SIZE     = 16,
  parameter int IN_SZ    = 4,
  parameter int OUT_SZ   = 2,
  parameter int FRAC     = 8,
  parameter int ACC_W    = 40,
  parameter int ACT_RELU = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  fc_layer_sequencer_if.master bus
);
  localparam int IW = clog2_min1(IN_SZ);
  localparam int JW = clog2_min1(OUT_SZ);
  localparam int AW = clog2_min1(IN_SZ * OUT_SZ);

  fc_state_e              state_q, state_d;
  logic [IW-1:0]          i_q, i_d, rd_idx_q;
  logic [JW-1:0]          j_q, j_d;
  logic                   rd_vld_q;
  logic [AW-1:0]          addr_s;
  logic                   mac_clear_s;
  logic signed [SIZE-1:0] result_s;

  logic                   busy_q, done_q, layer_clear_q, w_rd_en_q, load_en_q;
  logic [AW-1:0]          w_rd_addr_q;
  logic [SIZE-1:0]        load_address_q, load_value_q;

  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
  assign bus.layer_clear  = layer_clear_q;
  assign bus.w_rd_en      = w_rd_en_q;
  assign bus.w_rd_addr    = w_rd_addr_q;
  assign bus.load_en      = load_en_q;
  assign bus.load_address = load_address_q;
  assign bus.load_value   = load_value_q;

  // Next state and loop counters; counters leave their range only through state exit.
  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    j_d     = j_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) state_d = ST_CLEAR;
        else           state_d = ST_IDLE;
      end
      ST_CLEAR: begin
        i_d     = {IW{1'b0}};
        j_d     = {JW{1'b0}};
        state_d = ST_MAC;
      end
      ST_MAC: begin
        if (i_q == IW'(IN_SZ - 1)) state_d = ST_DRAIN;
        else                       i_d = i_q + IW'(1);
      end
      ST_DRAIN: state_d = ST_WRITE;
      ST_WRITE: begin
        i_d = {IW{1'b0}};
        if (j_q == JW'(OUT_SZ - 1)) begin
          state_d = ST_DONE;
        end else begin
          j_d     = j_q + JW'(1);
          state_d = ST_MAC;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Weight address of the read issued next cycle, and accumulator clear points.
  always_comb begin
    addr_s      = AW'(j_d) * AW'(IN_SZ) + AW'(i_d);
    mac_clear_s = (state_q == ST_CLEAR) || (state_q == ST_WRITE);
  end

  fc_mac_unit #(
    .SIZE(SIZE), .FRAC(FRAC), .ACC_W(ACC_W), .ACT_RELU(ACT_RELU)
  ) u_mac (
    .clk      (clk),
    .reset    (reset),
    .clear_i  (mac_clear_s),
    .acc_en_i (rd_vld_q),
    .a_i      (bus.in_values[rd_idx_q]),
    .b_i      (bus.w_rd_data),
    .result_o (result_s)
  );

  // State, counters, read-return tracking and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      i_q            <= {IW{1'b0}};
      j_q            <= {JW{1'b0}};
      rd_idx_q       <= {IW{1'b0}};
      rd_vld_q       <= 1'b0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      layer_clear_q  <= 1'b0;
      w_rd_en_q      <= 1'b0;
      w_rd_addr_q    <= {AW{1'b0}};
      load_en_q      <= 1'b0;
      load_address_q <= {SIZE{1'b0}};
      load_value_q   <= {SIZE{1'b0}};
    end else begin
      state_q        <= state_d;
      i_q            <= i_d;
      j_q            <= j_d;
      // The weight for the read issued this cycle returns next cycle.
      rd_idx_q       <= i_q;
      rd_vld_q       <= (state_q == ST_MAC);
      busy_q         <= (state_d != ST_IDLE);
      done_q         <= (state_d == ST_DONE);
      layer_clear_q  <= (state_d == ST_CLEAR);
      w_rd_en_q      <= (state_d == ST_MAC);
      w_rd_addr_q    <= (state_d == ST_MAC) ? addr_s : {AW{1'b0}};
      load_en_q      <= (state_d == ST_WRITE);
      load_address_q <= (state_d == ST_WRITE) ? SIZE'(j_q) : {SIZE{1'b0}};
      load_value_q   <= (state_d == ST_WRITE) ? result_s : {SIZE{1'b0}};
    end
  end
endmodule

// File: tb/tb_fc_layer_sequencer.sv
// Directed bench: three sequencer configurations, each with its own weight memory.
module tb_fc_layer_sequencer;
  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  fc_layer_sequencer_if #(.SIZE(16), .IN_SZ(4), .OUT_SZ(2)) bm ();
  fc_layer_sequencer_if #(.SIZE(16), .IN_SZ(4), .OUT_SZ(2)) bl ();
  fc_layer_sequencer_if #(.SIZE(16), .IN_SZ(1), .OUT_SZ(1)) bo ();

  fc_layer_sequencer #(.SIZE(16), .IN_SZ(4), .OUT_SZ(2), .FRAC(8), .ACC_W(40), .ACT_RELU(1))
    u_main (.clk(clk), .reset(reset), .bus(bm));
  fc_layer_sequencer #(.SIZE(16), .IN_SZ(4), .OUT_SZ(2), .FRAC(8), .ACC_W(40), .ACT_RELU(0))
    u_lin  (.clk(clk), .reset(reset), .bus(bl));
  fc_layer_sequencer #(.SIZE(16), .IN_SZ(1), .OUT_SZ(1), .FRAC(8), .ACC_W(40), .ACT_RELU(0))
    u_one  (.clk(clk), .reset(reset), .bus(bo));

  logic [15:0] mem_m [8];
  logic [15:0] mem_l [8];
  logic [15:0] mem_o [2];

  // Weight memories with one cycle of read latency.
  always @(posedge clk) begin
    if (bm.w_rd_en) bm.w_rd_data <= mem_m[bm.w_rd_addr];
    if (bl.w_rd_en) bl.w_rd_data <= mem_l[bl.w_rd_addr];
    if (bo.w_rd_en) bo.w_rd_data <= mem_o[bo.w_rd_addr];
  end

  int          ld_n [3];
  logic [15:0] ld_a [3][64];
  logic [15:0] ld_v [3][64];
  int          ld_c [3][64];
  int          dn_n [3];
  int          dn_c [3];
  int          rd_n;
  logic [2:0]  rd_a [128];
  int          cl_c;

  // Event log of writes, done pulses, weight reads and clears.
  always @(negedge clk) begin
    if (bm.load_en) begin
      if (ld_n[0] < 64) begin
        ld_a[0][ld_n[0]] <= bm.load_address;
        ld_v[0][ld_n[0]] <= bm.load_value;
        ld_c[0][ld_n[0]] <= cyc;
      end
      ld_n[0] <= ld_n[0] + 1;
    end
    if (bl.load_en) begin
      if (ld_n[1] < 64) begin
        ld_a[1][ld_n[1]] <= bl.load_address;
        ld_v[1][ld_n[1]] <= bl.load_value;
        ld_c[1][ld_n[1]] <= cyc;
      end
      ld_n[1] <= ld_n[1] + 1;
    end
    if (bo.load_en) begin
      if (ld_n[2] < 64) begin
        ld_a[2][ld_n[2]] <= bo.load_address;
        ld_v[2][ld_n[2]] <= bo.load_value;
        ld_c[2][ld_n[2]] <= cyc;
      end
      ld_n[2] <= ld_n[2] + 1;
    end
    if (bm.done) begin dn_n[0] <= dn_n[0] + 1; dn_c[0] <= cyc; end
    if (bl.done) begin dn_n[1] <= dn_n[1] + 1; dn_c[1] <= cyc; end
    if (bo.done) begin dn_n[2] <= dn_n[2] + 1; dn_c[2] <= cyc; end
    if (bm.w_rd_en) begin
      if (rd_n < 128) rd_a[rd_n] <= bm.w_rd_addr;
      rd_n <= rd_n + 1;
    end
    if (bm.layer_clear) cl_c <= cyc;
  end

  int t0, b_ld, b_dn, b_rd;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_start(input int which, input logic v);
    case (which)
      0:       bm.start = v;
      1:       bl.start = v;
      2:       bo.start = v;
      default: bm.start = 1'b0;
    endcase
  endtask

  function automatic logic [63:0] main_outs();
    return {bm.busy, bm.done, bm.w_rd_en, bm.layer_clear, bm.load_en,
            bm.w_rd_addr, bm.load_address, bm.load_value};
  endfunction

  // Start pulse at relative cycle 0, optional extra start pulses and a reset pulse.
  task automatic run(input int which, input int p1, input int p2, input int rst_at);
    @(negedge clk);
    b_ld = ld_n[which];
    b_dn = dn_n[which];
    b_rd = rd_n;
    set_start(which, 1'b1);
    t0 = cyc;
    for (int r = 1; r <= 24; r++) begin
      @(negedge clk);
      if (rst_at > 0 && r == rst_at + 1) check("abort_outputs_zero", main_outs(), 64'd0);
      set_start(which, (r == p1) || (r == p2));
      reset = (r == rst_at);
    end
    set_start(which, 1'b0);
    reset = 1'b0;
  endtask

  task automatic chk_loads(input string tag, input int w, input int n,
                           input logic [15:0] v0, input logic [15:0] v1);
    check({tag, "_nload"}, 64'(ld_n[w] - b_ld), 64'(n));
    check({tag, "_ndone"}, 64'(dn_n[w] - b_dn), 64'd1);
    check({tag, "_addr0"}, 64'(ld_a[w][b_ld]), 64'd0);
    check({tag, "_val0"},  64'(ld_v[w][b_ld]), 64'(v0));
    if (n > 1) begin
      check({tag, "_addr1"}, 64'(ld_a[w][b_ld + 1]), 64'd1);
      check({tag, "_val1"},  64'(ld_v[w][b_ld + 1]), 64'(v1));
    end
  endtask

  initial begin
    reset = 1'b1;
    bm.start = 1'b0; bl.start = 1'b0; bo.start = 1'b0;
    bm.in_values = '{default: 16'h0000};
    bl.in_values = '{default: 16'h0000};
    bo.in_values = '{default: 16'h0000};
    for (int k = 0; k < 8; k++) begin mem_m[k] = 16'h0000; mem_l[k] = 16'h0000; end
    mem_o[0] = 16'h0000; mem_o[1] = 16'h0000;
    repeat (3) @(negedge clk);
    check("reset_main_outputs", main_outs(), 64'd0);
    check("reset_lin_outputs", {bl.busy, bl.done, bl.w_rd_en, bl.layer_clear, bl.load_en,
                                bl.w_rd_addr, bl.load_address, bl.load_value}, 64'd0);
    check("reset_one_outputs", {bo.busy, bo.done, bo.w_rd_en, bo.layer_clear, bo.load_en,
                                bo.w_rd_addr, bo.load_address, bo.load_value}, 64'd0);
    reset = 1'b0;

    // 1.0 * 0.5 summed four times = 2.0 on both outputs; timing landmarks.
    bm.in_values = {16'h0100, 16'h0100, 16'h0100, 16'h0100};
    for (int k = 0; k < 8; k++) mem_m[k] = 16'h0080;
    run(0, 0, 0, 0);
    chk_loads("t1", 0, 2, 16'h0200, 16'h0200);
    check("t1_clear_cycle", 64'(cl_c - t0), 64'd1);
    check("t1_first_load_cycle", 64'(ld_c[0][b_ld] - t0), 64'd7);
    check("t1_done_cycle", 64'(dn_c[0] - t0), 64'd14);

    // 1+2+3+4 = 10 for row weight 1.0, 20 for row weight 2.0; read order.
    bm.in_values = {16'h0100, 16'h0200, 16'h0300, 16'h0400};
    for (int k = 0; k < 8; k++) mem_m[k] = (k < 4) ? 16'h0100 : 16'h0200;
    run(0, 0, 0, 0);
    chk_loads("t2", 0, 2, 16'h0A00, 16'h1400);
    check("t2_nreads", 64'(rd_n - b_rd), 64'd8);
    for (int k = 0; k < 8; k++) check("t2_rd_addr", 64'(rd_a[b_rd + k]), 64'(k));

    // Positive saturation, then negative saturation rectified to zero.
    bm.in_values = {16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF};
    for (int k = 0; k < 8; k++) mem_m[k] = 16'h7FFF;
    run(0, 0, 0, 0);
    chk_loads("t3_pos_sat", 0, 2, 16'h7FFF, 16'h7FFF);
    for (int k = 0; k < 8; k++) mem_m[k] = 16'h8000;
    run(0, 0, 0, 0);
    chk_loads("t3_relu", 0, 2, 16'h0000, 16'h0000);

    // Negative saturation without activation.
    bl.in_values = {16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF};
    for (int k = 0; k < 8; k++) mem_l[k] = 16'h8000;
    run(1, 0, 0, 0);
    chk_loads("t3_neg_sat", 1, 2, 16'h8000, 16'h8000);

    // Start re-pulsed while busy is ignored.
    bm.in_values = {16'h0100, 16'h0100, 16'h0100, 16'h0100};
    for (int k = 0; k < 8; k++) mem_m[k] = 16'h0080;
    run(0, 3, 9, 0);
    chk_loads("t4", 0, 2, 16'h0200, 16'h0200);
    check("t4_done_cycle", 64'(dn_c[0] - t0), 64'd14);

    // Reset mid-run aborts without writes or done; a fresh run then completes.
    bm.in_values = {16'h0100, 16'h0200, 16'h0300, 16'h0400};
    for (int k = 0; k < 8; k++) mem_m[k] = (k < 4) ? 16'h0100 : 16'h0200;
    run(0, 0, 0, 5);
    check("t5_abort_nload", 64'(ld_n[0] - b_ld), 64'd0);
    check("t5_abort_ndone", 64'(dn_n[0] - b_dn), 64'd0);
    run(0, 0, 0, 0);
    chk_loads("t5_rerun", 0, 2, 16'h0A00, 16'h1400);

    // Single-input single-output layer: 1.0 * -1.0 = -1.0.
    bo.in_values = {16'h0100};
    mem_o[0] = 16'hFF00;
    run(2, 0, 0, 0);
    chk_loads("t6", 2, 1, 16'hFF00, 16'h0000);
    check("t6_done_cycle", 64'(dn_c[2] - t0), 64'd5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
